tcp_vlg_tx_ingress: RTL and testbench

TCP_VLG_TX_INGRESS -- requirements
Module: tcp_vlg_tx_ingress

---
 rtl/tcp_vlg_tx_ingress.sv | 190 +++++++++++++++++++
 tb/tb_tcp_vlg_tx_ingress.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_vlg_tx_ingress.sv
// TCP transmit ingress: writes user bytes into the circular tx buffer, tracks
// sequence pointers and hands segment descriptors (seq, len) to the tx controller.
module tcp_vlg_tx_ingress #(
  parameter int unsigned D_W        = 12,
  parameter int unsigned MSS        = 1460,
  parameter int unsigned WAIT_TICKS = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           connected,
  input  logic           init,
  input  logic [31:0]    init_seq,
  input  logic           flush,
  output logic           flushed,
  input  logic [31:0]    ack_seq,
  input  logic [7:0]     usr_dat,
  input  logic           usr_val,
  input  logic           usr_snd,
  output logic           usr_cts,
  output logic [D_W-1:0] ram_a,
  output logic [7:0]     ram_d,
  output logic           ram_w,
  output logic [31:0]    loc_seq,
  output logic           send,
  output logic [31:0]    send_seq,
  output logic [15:0]    send_len,
  input  logic           sent
);

  localparam int unsigned     T_W   = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS + 1) : 1;
  localparam logic [T_W-1:0]  T_MAX = T_W'(WAIT_TICKS - 1);
  localparam logic [15:0]     MSS16 = 16'(MSS);
  localparam logic [32:0]     DEPTH = 33'd1 << D_W;

  typedef enum logic [1:0] {IDLE, ACCUM, SEND, FLUSH} state_t;

  state_t         r_state;
  state_t         w_next;

  logic [31:0]    r_loc_seq;
  logic [31:0]    r_disp_seq;
  logic [31:0]    r_send_seq;
  logic [15:0]    r_send_len;
  logic [T_W-1:0] r_timer;
  logic           r_snd;
  logic           r_cts;
  logic           r_ram_w;
  logic [D_W-1:0] r_ram_a;
  logic [7:0]     r_ram_d;
  logic           r_flushed;
  logic [D_W-1:0] r_fcnt;

  logic [31:0]    w_used;
  logic [31:0]    w_diff;
  logic [15:0]    w_pend;
  logic [15:0]    w_seg_len;
  logic [15:0]    w_rest;
  logic           w_room;
  logic           w_in_flush;
  logic           w_send;
  logic           w_enter_send;
  logic           w_flush_done;
  logic           w_init;
  logic           w_acc;

  assign w_used    = r_loc_seq - ack_seq;
  // free > 2 rewritten as used < depth-2 so no signed arithmetic is needed
  assign w_room    = ({1'b0, w_used} < (DEPTH - 33'd2));
  assign w_diff    = r_loc_seq - r_disp_seq;
  assign w_pend    = w_diff[15:0];
  assign w_seg_len = (w_pend >= MSS16) ? MSS16 : w_pend;
  assign w_rest    = w_pend - r_send_len;

  assign w_flush_done = w_in_flush && (r_fcnt == '1);
  assign w_init       = init && !flush && !w_in_flush;
  assign w_acc        = usr_val && r_cts && !init && !flush && !w_in_flush;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush outranks init, init outranks normal flow
  always_comb begin
    w_next = r_state;
    if (r_state == FLUSH) begin
      if (w_flush_done) begin
        w_next = IDLE;
      end
    end else if (flush) begin
      w_next = FLUSH;
    end else if (init) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pend != '0) begin
            w_next = ACCUM;
          end
        end
        ACCUM: begin
          if ((w_pend >= MSS16) || r_snd || (r_timer == T_MAX)) begin
            w_next = SEND;
          end
        end
        SEND: begin
          if (sent) begin
            w_next = (w_rest != '0) ? ACCUM : IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // FSM-derived controls
  always_comb begin
    w_in_flush   = (r_state == FLUSH);
    w_send       = (r_state == SEND);
    w_enter_send = (w_next == SEND) && (r_state != SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loc_seq  <= '0;
      r_disp_seq <= '0;
      r_send_seq <= '0;
      r_send_len <= '0;
      r_timer    <= '0;
      r_snd      <= 1'b0;
      r_cts      <= 1'b0;
      r_ram_w    <= 1'b0;
      r_ram_a    <= '0;
      r_ram_d    <= '0;
      r_flushed  <= 1'b0;
      r_fcnt     <= '0;
    end else begin
      r_ram_w   <= 1'b0;
      r_flushed <= 1'b0;
      r_cts     <= connected && !flush && !w_in_flush && w_room;
      r_snd     <= (w_init || w_enter_send) ? 1'b0 : (r_snd || usr_snd);
      r_timer   <= ((r_state == ACCUM) && (w_next == ACCUM) && !w_acc) ? r_timer + 1'b1 : '0;

      if (w_in_flush) begin
        r_ram_w <= 1'b1;
        r_ram_a <= r_fcnt;
        r_ram_d <= '0;
        r_fcnt  <= r_fcnt + 1'b1;
        if (w_flush_done) begin
          r_flushed  <= 1'b1;
          r_disp_seq <= r_loc_seq;
        end
      end else if (flush) begin
        r_fcnt <= '0;
      end else if (init) begin
        r_loc_seq  <= init_seq;
        r_disp_seq <= init_seq;
      end else begin
        if (w_acc) begin
          r_ram_w   <= 1'b1;
          r_ram_a   <= r_loc_seq[D_W-1:0];
          r_ram_d   <= usr_dat;
          r_loc_seq <= r_loc_seq + 32'd1;
        end
        if (w_enter_send) begin
          r_send_seq <= r_disp_seq;
          r_send_len <= w_seg_len;
        end
        if (w_send && sent) begin
          r_disp_seq <= r_disp_seq + 32'(r_send_len);
        end
      end
    end
  end

  assign usr_cts  = r_cts;
  assign ram_a    = r_ram_a;
  assign ram_d    = r_ram_d;
  assign ram_w    = r_ram_w;
  assign loc_seq  = r_loc_seq;
  assign send     = w_send;
  assign send_seq = r_send_seq;
  assign send_len = r_send_len;
  assign flushed  = r_flushed;

endmodule

// File: tb/tb_tcp_vlg_tx_ingress.sv
// Scoreboard bench for tcp_vlg_tx_ingress: a byte-level model predicts buffer
// writes, loc_seq and usr_cts; tests queue the segment descriptors they expect.
module tb_tcp_vlg_tx_ingress;

  localparam int D_W   = 12;
  localparam int MSS   = 1460;
  localparam int WT    = 100;
  localparam int DEPTH = 1 << D_W;

  logic           clk = 1'b0;
  logic           rst_n, connected, init, flush, flushed;
  logic [31:0]    init_seq, ack_seq, loc_seq, send_seq;
  logic [7:0]     usr_dat, ram_d;
  logic           usr_val, usr_snd, usr_cts, ram_w, send, sent;
  logic [D_W-1:0] ram_a;
  logic [15:0]    send_len;

  tcp_vlg_tx_ingress #(.D_W(D_W), .MSS(MSS), .WAIT_TICKS(WT)) dut (
    .clk(clk), .rst_n(rst_n), .connected(connected), .init(init), .init_seq(init_seq),
    .flush(flush), .flushed(flushed), .ack_seq(ack_seq), .usr_dat(usr_dat),
    .usr_val(usr_val), .usr_snd(usr_snd), .usr_cts(usr_cts), .ram_a(ram_a),
    .ram_d(ram_d), .ram_w(ram_w), .loc_seq(loc_seq), .send(send),
    .send_seq(send_seq), .send_len(send_len), .sent(sent)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] seq; logic [15:0] len; } desc_t;
  typedef struct { logic [D_W-1:0] addr; logic [7:0] data; } wr_t;

  desc_t       q_desc[$];
  wr_t         q_wr[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_flushed = 0;
  bit          mon_en = 1'b0;
  bit          resp_en = 1'b1;
  bit          ack_track = 1'b1;
  logic [31:0] ack_fix = '0;

  logic [31:0] m_loc;
  bit          m_cts;
  int          m_fl_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name, input logic [63:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
  endtask

  // Reference model: byte acceptance, buffer writes, credit and flush duration
  initial begin
    logic [31:0] used;
    bit          acc, cts_n;
    m_loc = '0; m_cts = 1'b0; m_fl_left = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_loc = '0; m_cts = 1'b0; m_fl_left = 0;
      end else begin
        used  = m_loc - ack_seq;
        acc   = usr_val && m_cts && !flush && !init && (m_fl_left == 0);
        cts_n = connected && !flush && (m_fl_left == 0) && ((longint'(DEPTH) - longint'(used)) > 2);
        if (m_fl_left > 0) begin
          m_fl_left--;
        end else if (flush) begin
          m_fl_left = DEPTH;
          for (int a = 0; a < DEPTH; a++) q_wr.push_back('{addr: D_W'(a), data: 8'h00});
        end else if (init) begin
          m_loc = init_seq;
        end else if (acc) begin
          q_wr.push_back('{addr: m_loc[D_W-1:0], data: usr_dat});
          m_loc = m_loc + 32'd1;
        end
        m_cts = cts_n;
      end
    end
  end

  // Remote acknowledgement: follows the model pointer or holds a fixed value
  initial begin
    ack_seq = '0;
    forever begin
      @(negedge clk);
      ack_seq = ack_track ? m_loc : ack_fix;
    end
  end

  // tx_ctl stand-in: accepts a presented descriptor after a random delay
  initial begin
    int cnt;
    sent = 1'b0;
    cnt  = 2;
    forever begin
      @(negedge clk);
      sent = 1'b0;
      if (resp_en && send) begin
        if (cnt == 0) begin
          sent = 1'b1;
          cnt  = $urandom_range(0, 4);
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor
  initial begin
    bit    prev_send;
    desc_t cur, d;
    wr_t   w;
    prev_send = 1'b0;
    cur = '{seq: '0, len: '0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("loc_seq", 64'(loc_seq), 64'(m_loc));
        chk("usr_cts", 64'(usr_cts), 64'(m_cts));
        if (ram_w) begin
          if (q_wr.size() == 0) begin
            flag_fail("ram_write_unexpected", 64'({ram_a, ram_d}));
          end else begin
            w = q_wr.pop_front();
            chk("ram_a", 64'(ram_a), 64'(w.addr));
            chk("ram_d", 64'(ram_d), 64'(w.data));
          end
        end
        if (send && !prev_send) begin
          if (q_desc.size() == 0) begin
            flag_fail("desc_unexpected", 64'({send_seq, send_len}));
          end else begin
            d = q_desc.pop_front();
            cur = d;
            chk("send_seq", 64'(send_seq), 64'(d.seq));
            chk("send_len", 64'(send_len), 64'(d.len));
          end
        end else if (send) begin
          chk("desc_stable", 64'({send_seq, send_len}), 64'({cur.seq, cur.len}));
        end
        if (flushed) n_flushed++;
      end
      prev_send = send;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] d);
    usr_dat = d;
    usr_val = 1'b1;
    @(negedge clk);
    usr_val = 1'b0;
  endtask

  task automatic write_burst(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      put_byte(8'($urandom));
      if (maxgap > 0) tick($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_init(input logic [31:0] s);
    init_seq = s;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    tick(3);
  endtask

  task automatic pulse_snd();
    usr_snd = 1'b1;
    @(negedge clk);
    usr_snd = 1'b0;
  endtask

  // Expected descriptors for a steady stream: full MSS segments, then the remainder
  task automatic expect_stream(input logic [31:0] base, input int total);
    int          rem;
    logic [31:0] s;
    rem = total;
    s   = base;
    while (rem > 0) begin
      int l;
      l = (rem > MSS) ? MSS : rem;
      q_desc.push_back('{seq: s, len: 16'(l)});
      s   = s + 32'(l);
      rem = rem - l;
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((q_desc.size() != 0 || send) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("descriptors_outstanding", 64'(q_desc.size()), 64'd0);
    tick(3);
  endtask

  initial begin
    logic [31:0] base;
    int          n;
    rst_n = 1'b0; connected = 1'b1; init = 1'b0; init_seq = '0; flush = 1'b0;
    usr_dat = '0; usr_val = 1'b0; usr_snd = 1'b0;
    tick(3);
    chk("rst_usr_cts",  64'(usr_cts),  64'd0);
    chk("rst_ram_w",    64'(ram_w),    64'd0);
    chk("rst_ram_a",    64'(ram_a),    64'd0);
    chk("rst_send",     64'(send),     64'd0);
    chk("rst_send_seq", 64'(send_seq), 64'd0);
    chk("rst_send_len", 64'(send_len), 64'd0);
    chk("rst_loc_seq",  64'(loc_seq),  64'd0);
    chk("rst_flushed",  64'(flushed),  64'd0);
    mon_en = 1'b1;
    rst_n = 1'b1;
    tick(3);

    // Timeout dispatch of a short payload
    do_init(32'h0000_1000);
    q_desc.push_back('{seq: 32'h0000_1000, len: 16'd10});
    write_burst(10, 0);
    n = 1;
    while (!send && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency_in_range", 64'((n >= WT) && (n <= WT + 2)), 64'd1);
    drain(100);
    chk("loc_after_timeout", 64'(loc_seq), 64'h100A);

    // 3000-byte stream from a random base
    base = $urandom;
    do_init(base);
    expect_stream(base, 3000);
    write_burst(3000, 1);
    drain(2000);
    chk("loc_after_stream", 64'(loc_seq), 64'(base + 32'd3000));

    // Sequence wrap with forced dispatch
    do_init(32'hFFFF_FFFE);
    q_desc.push_back('{seq: 32'hFFFF_FFFE, len: 16'd4});
    write_burst(4, 0);
    pulse_snd();
    drain(200);
    chk("loc_after_wrap", 64'(loc_seq), 64'h2);

    // Random bursts, dispatched by usr_snd or by timeout
    for (int r = 0; r < 8; r++) begin
      bit use_snd;
      n = $urandom_range(1, 300);
      use_snd = 1'($urandom_range(0, 1));
      q_desc.push_back('{seq: m_loc, len: 16'(n)});
      write_burst(n, 3);
      if (use_snd) pulse_snd();
      drain(1500);
    end

    // init beats a byte presented in the same cycle
    init_seq = 32'h0000_0300;
    init = 1'b1;
    usr_dat = 8'hAA;
    usr_val = 1'b1;
    @(negedge clk);
    init = 1'b0;
    usr_val = 1'b0;
    tick(2);
    chk("init_wins_loc", 64'(loc_seq), 64'h300);

    // Disconnect closes the gate but the pending segment still goes out
    q_desc.push_back('{seq: m_loc, len: 16'd20});
    write_burst(20, 0);
    connected = 1'b0;
    tick(2);
    chk("cts_disconnected", 64'(usr_cts), 64'd0);
    pulse_snd();
    drain(200);
    connected = 1'b1;
    tick(3);

    // Buffer fill with ack frozen
    do_init(32'h0000_2000);
    ack_fix = 32'h0000_2000;
    ack_track = 1'b0;
    tick(2);
    expect_stream(32'h0000_2000, 4095);
    usr_val = 1'b1;
    for (int i = 0; i < 4200; i++) begin
      usr_dat = 8'($urandom);
      @(negedge clk);
    end
    usr_val = 1'b0;
    chk("loc_when_full", 64'(loc_seq), 64'(32'h2000 + 32'd4095));
    chk("cts_when_full", 64'(usr_cts), 64'd0);
    ack_fix = 32'h0000_2000 + 32'd100;
    tick(3);
    chk("cts_after_ack", 64'(usr_cts), 64'd1);
    drain(3000);
    ack_track = 1'b1;
    tick(3);

    // Flush while a descriptor is presented
    q_desc.push_back('{seq: m_loc, len: 16'd5});
    resp_en = 1'b0;
    write_burst(5, 0);
    pulse_snd();
    n = 0;
    while (!send && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_before_flush", 64'(send), 64'd1);
    n_flushed = 0;
    flush = 1'b1;
    @(negedge clk);
    chk("send_drop_on_flush", 64'(send), 64'd0);
    tick(2);
    flush = 1'b0;
    n = 0;
    while (n_flushed == 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    tick(10);
    chk("flushed_pulses", 64'(n_flushed), 64'd1);
    chk("zero_writes_done", 64'(q_wr.size()), 64'd0);
    chk("send_idle_after_flush", 64'(send), 64'd0);
    resp_en = 1'b1;
    q_desc.push_back('{seq: m_loc, len: 16'd3});
    write_burst(3, 0);
    pulse_snd();
    drain(200);

    // Reset in the middle of accumulation
    do_init(32'h0000_7000);
    write_burst(500, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_usr_cts",  64'(usr_cts),  64'd0);
    chk("mid_rst_ram_w",    64'(ram_w),    64'd0);
    chk("mid_rst_ram_a",    64'(ram_a),    64'd0);
    chk("mid_rst_ram_d",    64'(ram_d),    64'd0);
    chk("mid_rst_send",     64'(send),     64'd0);
    chk("mid_rst_send_seq", 64'(send_seq), 64'd0);
    chk("mid_rst_send_len", 64'(send_len), 64'd0);
    chk("mid_rst_flushed",  64'(flushed),  64'd0);
    chk("mid_rst_loc_seq",  64'(loc_seq),  64'd0);
    rst_n = 1'b1;
    tick(300);
    chk("no_send_after_rst", 64'(send), 64'd0);
    chk("no_desc_pending", 64'(q_desc.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
